// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// The state enum is public so the debug state output can be decoded.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;

  localparam int DEF_ADDR_W      = 13;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the two-port memory arbiter.
// Handshake: a port holds req (with we/addr/wdata) until it sees gnt; the arbiter
// answers each accepted request with exactly one done pulse, then req is sampled afresh.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic [1:0]             req;
  logic [1:0]             we;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdata;
  logic [1:0]             gnt;
  logic [1:0]             done;
  logic [DATA_W-1:0]      rdata;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic                   mem_read;
  logic                   mem_write;
  logic [DATA_W-1:0]      mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, done, rdata, mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, done, rdata, mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter giving a CPU port and a DMA port turns on one single-port memory.
// One access in flight: IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE -> IDLE.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output state_t              state_dbg
);

  state_t            state, state_nxt;
  logic              owner;
  logic              last_owner;
  logic              sel;
  logic [3:0]        cnt;
  logic              we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata_q;

  // A lone requester wins; on a tie the port that did not go last wins.
  assign sel = bus.req[PORT_DMA] & (~bus.req[PORT_CPU] | ~last_owner);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|bus.req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      cnt         <= 4'd0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            owner       <= sel;
            we_q        <= bus.we[sel];
            mem_addr_q  <= bus.addr[sel];
            mem_wdata_q <= bus.wdata[sel];
            cnt         <= 4'(WAIT_CYCLES);
          end
        end
        ACCESS: begin
          if (cnt != 4'd0)  cnt     <= cnt - 4'd1;
          else if (!we_q)   rdata_q <= bus.mem_rdata;
        end
        DONE:    last_owner <= owner;
        default: ;
      endcase
    end
  end

  // Strobes decode from registered state so reset drops them at once.
  assign bus.gnt       = (state == ACCESS) ? {owner, ~owner} : 2'b00;
  assign bus.done      = (state == DONE)   ? {owner, ~owner} : 2'b00;
  assign bus.mem_read  = (state == ACCESS) & ~we_q;
  assign bus.mem_write = (state == ACCESS) & we_q & (cnt == 4'd0);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = rdata_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0
// instance sharing one behavioural memory.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 13;
  localparam int DW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
  state_t st1, st0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .bus(b1.slave), .state_dbg(st1)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .bus(b0.slave), .state_dbg(st0)
  );

  // memory model: background pattern addr^0x5A, 0x005 holds 0xA7
  logic [DW-1:0] mem [0:8191];
  logic mem_ready = 1'b0;
  int   wr_cnt = 0;

  assign b1.mem_rdata = mem[b1.mem_addr];
  assign b0.mem_rdata = mem[b0.mem_addr];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 8192; i++) mem[i] <= (i == 5) ? 8'hA7 : (8'(i) ^ 8'h5A);
      mem_ready <= 1'b1;
    end else if (b1.mem_write) begin
      mem[b1.mem_addr] <= b1.mem_wdata;
    end
  end

  always @(posedge clk) if (b1.mem_write) wr_cnt <= wr_cnt + 1;

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b1.req = 2'b00; b1.we = 2'b00; b1.addr = '0; b1.wdata = '0;
    b0.req = 2'b00; b0.we = 2'b00; b0.addr = '0; b0.wdata = '0;
  endtask

  int wr0;
  int n_done;
  int done_seen;
  logic [1:0] owners [4];
  int stamps [4];

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();

    // reset state
    check("rst_gnt",   b1.gnt, 2'b00);
    check("rst_done",  b1.done, 2'b00);
    check("rst_rd",    b1.mem_read, 1'b0);
    check("rst_wr",    b1.mem_write, 1'b0);
    check("rst_addr",  b1.mem_addr, 13'h0);
    check("rst_wdata", b1.mem_wdata, 8'h00);
    check("rst_rdata", b1.rdata, 8'h00);
    check("rst_state", st1, IDLE);
    rst = 1'b0;
    tick();

    // CPU read of 0x005
    b1.req = 2'b01; b1.addr[0] = 13'h005;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) b1.req = 2'b00;
      check("rd_gnt",  b1.gnt, 2'b01);
      check("rd_strb", b1.mem_read, 1'b1);
      check("rd_addr", b1.mem_addr, 13'h005);
      check("rd_nodone", b1.done, 2'b00);
    end
    tick();
    check("rd_done",  b1.done, 2'b01);
    check("rd_rdata", b1.rdata, 8'hA7);
    check("rd_gnt_off", b1.gnt, 2'b00);
    tick();
    check("rd_done_1cyc", b1.done, 2'b00);
    check("rd_idle", st1, IDLE);

    // DMA write 0x3C to 0x1F0
    wr0 = wr_cnt;
    done_seen = 0;
    b1.req = 2'b10; b1.we = 2'b10; b1.addr[1] = 13'h1F0; b1.wdata[1] = 8'h3C;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) begin b1.req = 2'b00; b1.we = 2'b00; end
      if (c <= 3) check("wr_gnt", b1.gnt, 2'b10);
      if (b1.mem_write) begin
        check("wr_addr",  b1.mem_addr, 13'h1F0);
        check("wr_wdata", b1.mem_wdata, 8'h3C);
        check("wr_cycle", c, 3);
      end
      check("wr_noread", b1.mem_read, 1'b0);
      if (b1.done != 2'b00) begin
        check("wr_done", b1.done, 2'b10);
        check("wr_done_cycle", c, 4);
        done_seen++;
      end
    end
    check("wr_count", wr_cnt - wr0, 1);
    check("wr_done_seen", done_seen, 1);
    check("wr_rdata_kept", b1.rdata, 8'hA7);
    check("wr_mem", mem[13'h1F0], 8'h3C);

    // contention straight after reset: CPU, DMA, CPU, DMA
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    exp_q = '{32'h1, 32'h2, 32'h1, 32'h2};
    for (int k = 0; k < 4; k++) begin owners[k] = 2'b00; stamps[k] = 0; end
    n_done = 0;
    b1.req = 2'b11; b1.we = 2'b00; b1.addr[0] = 13'h005; b1.addr[1] = 13'h1F0;
    for (int c = 1; c <= 40 && n_done < 4; c++) begin
      tick();
      if (b1.done != 2'b00) begin
        owners[n_done] = b1.done;
        stamps[n_done] = c;
        n_done++;
      end
    end
    b1.req = 2'b00;
    check("rr_count", n_done, 4);
    check("rr_first_cycle", stamps[0], 4);
    for (int k = 0; k < 4; k++) begin
      check("rr_owner", owners[k], exp_q.pop_front());
      if (k > 0) check("rr_gap", stamps[k] - stamps[k-1], 5);
    end
    repeat (2) tick();

    // request dropped and addr changed in 2nd ACCESS cycle
    b1.req = 2'b01; b1.we = 2'b00; b1.addr[0] = 13'h010;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 2) begin b1.addr[0] = 13'h123; b1.req = 2'b00; end
      check("drop_addr", b1.mem_addr, 13'h010);
      if (c <= 3) check("drop_gnt", b1.gnt, 2'b01);
      if (c == 4) begin
        check("drop_done",  b1.done, 2'b01);
        check("drop_rdata", b1.rdata, 8'h4A);
      end
    end
    repeat (2) tick();

    // reset in 2nd ACCESS cycle of a write
    wr0 = wr_cnt;
    b1.req = 2'b01; b1.we = 2'b01; b1.addr[0] = 13'h0AA; b1.wdata[0] = 8'h77;
    tick();
    check("rstm_c1_wr", b1.mem_write, 1'b0);
    tick();
    check("rstm_c2_gnt", b1.gnt, 2'b01);
    rst = 1'b1;
    #1;
    check("rstm_gnt",   b1.gnt, 2'b00);
    check("rstm_done",  b1.done, 2'b00);
    check("rstm_rd",    b1.mem_read, 1'b0);
    check("rstm_wr",    b1.mem_write, 1'b0);
    check("rstm_addr",  b1.mem_addr, 13'h0);
    check("rstm_wdata", b1.mem_wdata, 8'h00);
    check("rstm_rdata", b1.rdata, 8'h00);
    check("rstm_state", st1, IDLE);
    b1.req = 2'b11; b1.we = 2'b00;
    repeat (2) begin
      tick();
      check("rstm_hold_done", b1.done, 2'b00);
    end
    rst = 1'b0;
    tick();
    check("rstm_cpu_first", b1.gnt, 2'b01);
    check("rstm_no_write", wr_cnt - wr0, 0);
    check("rstm_mem_kept", mem[13'h0AA], 8'hF0);
    b1.req = 2'b00;
    repeat (4) tick();

    // WAIT_CYCLES=0 instance: back-to-back CPU reads of 0x000 and 0x001
    exp_q = '{32'h5A, 32'h5B};
    n_done = 0;
    b0.req = 2'b01; b0.we = 2'b00; b0.addr[0] = 13'h000;
    for (int c = 1; c <= 12 && n_done < 2; c++) begin
      tick();
      if (c == 1) begin
        check("w0_gnt", b0.gnt, 2'b01);
        check("w0_rd",  b0.mem_read, 1'b1);
      end
      if (b0.done != 2'b00) begin
        check("w0_done",  b0.done, 2'b01);
        check("w0_rdata", b0.rdata, exp_q.pop_front());
        stamps[n_done] = c;
        n_done++;
        b0.addr[0] = 13'h001;
      end
    end
    b0.req = 2'b00;
    check("w0_count", n_done, 2);
    check("w0_first_cycle", stamps[0], 2);
    check("w0_gap", stamps[1] - stamps[0], 3);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
